// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback port arbiter.
// Imported by the interface, the picker and the arbiter top.
package wb_port_arbiter_pkg;

  localparam int N_WB_FU     = 4;
  localparam int WB_MAX_WAIT = 8;
  localparam int WB_DATA_W   = 32;
  localparam int WAIT_W      = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_w(N_WB_FU)-1:0] fu_idx_t;

  typedef struct packed {
    logic [4:0]           rd;
    logic [WB_DATA_W-1:0] data;
    logic                 spec;
  } fu_wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// FU completion side and writeback side of the arbiter.
// master is the arbiter, slave is the surrounding pipeline.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int N_FU   = N_WB_FU,
  parameter int DATA_W = WB_DATA_W,
  parameter int IW     = idx_w(N_FU)
);

  logic [N_FU-1:0]             fu_req;
  logic [N_FU-1:0][4:0]        fu_rd;
  logic [N_FU-1:0][DATA_W-1:0] fu_data;
  logic [N_FU-1:0]             fu_spec;
  logic [N_FU-1:0]             fu_ack;
  logic                        branch_miss;
  logic                        branch_resolved;
  logic                        wb_ready;
  logic                        wb_valid;
  logic [4:0]                  wb_rd;
  logic [DATA_W-1:0]           wb_data;
  logic [IW-1:0]               wb_fu;
  logic                        wb_spec;

  modport master (
    input  fu_req, fu_rd, fu_data, fu_spec,
    input  branch_miss, branch_resolved, wb_ready,
    output fu_ack, wb_valid, wb_rd, wb_data,
    output wb_fu, wb_spec
  );

  modport slave (
    output fu_req, fu_rd, fu_data, fu_spec,
    output branch_miss, branch_resolved, wb_ready,
    input  fu_ack, wb_valid, wb_rd, wb_data,
    input  wb_fu, wb_spec
  );

endinterface

// File: rtl/wb_port_arbiter_rr_picker.sv
// Combinational round-robin picker with a priority override.
// Priority bits win lowest-index first, else first req at/after ptr.
module wb_port_arbiter_rr_picker
  import wb_port_arbiter_pkg::*;
#(
  parameter int N  = N_WB_FU,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  pri,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand [N];

  // candidate order: ptr, ptr+1, ... wrapping at N
  always_comb begin
    for (int k = 0; k < N; k++) begin
      cand[k] = IW'((int'(ptr) + k) % N);
    end
  end

  // pick the winner; loops run high to low so the earliest hit sticks
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    if (|pri) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pri[i]) idx = IW'(i);
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req[cand[k]]) idx = cand[k];
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file writeback port among the FUs.
// Round-robin with starvation guard, one-entry output register, flush.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int N_FU     = N_WB_FU,
  parameter int MAX_WAIT = WB_MAX_WAIT,
  parameter int DATA_W   = WB_DATA_W,
  parameter int IW       = idx_w(N_FU)
) (
  input logic            CLK,
  input logic            nRST,
  wb_port_arbiter_if.master bus
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic [IW-1:0]     fu;
    logic              spec;
  } wb_t;

  wb_t               wb_q;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     ptr_nxt;
  logic [IW-1:0]     g_idx;
  logic [N_FU-1:0]   elig;
  logic [N_FU-1:0]   pri;
  logic [N_FU-1:0]   grant;
  logic [N_FU-1:0]   ack;
  logic              any;
  logic              squash;
  logic              free;
  logic              take;
  logic [WAIT_W-1:0] wait_cnt [N_FU];

  assign elig = bus.fu_req
              & ~(bus.fu_spec & {N_FU{bus.branch_miss}});

  // requesters refused for too long jump the round-robin order
  always_comb begin
    pri = '0;
    for (int i = 0; i < N_FU; i++) begin
      pri[i] = elig[i]
             && (wait_cnt[i] >= WAIT_W'(MAX_WAIT));
    end
  end

  wb_port_arbiter_rr_picker #(
    .N  (N_FU),
    .IW (IW)
  ) u_pick (
    .req   (elig),
    .pri   (pri),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (g_idx),
    .any   (any)
  );

  assign squash  = bus.branch_miss & wb_q.valid & wb_q.spec;
  assign free    = ~wb_q.valid | bus.wb_ready | squash;
  assign take    = nRST & free & any;
  assign ack     = take ? grant : '0;
  assign ptr_nxt = (g_idx == IW'(N_FU - 1)) ? '0 : g_idx + 1'b1;

  // output register: load on grant, else drain, squash or resolve
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wb_q   <= '0;
      rr_ptr <= '0;
    end else if (take) begin
      wb_q <= '{valid: 1'b1,
                rd:    bus.fu_rd[g_idx],
                data:  bus.fu_data[g_idx],
                fu:    g_idx,
                spec:  bus.fu_spec[g_idx]};
      rr_ptr <= ptr_nxt;
    end else begin
      if (wb_q.valid & (bus.wb_ready | squash))
        wb_q.valid <= 1'b0;
      if (bus.branch_resolved & ~bus.branch_miss)
        wb_q.spec <= 1'b0;
    end
  end

  // per-FU refusal counters, saturating
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_FU; i++) begin
      if (!nRST || !bus.fu_req[i] || ack[i])
        wait_cnt[i] <= '0;
      else if (wait_cnt[i] != '1)
        wait_cnt[i] <= wait_cnt[i] + 1'b1;
    end
  end

  assign bus.fu_ack   = ack;
  assign bus.wb_valid = wb_q.valid;
  assign bus.wb_rd    = wb_q.rd;
  assign bus.wb_data  = wb_q.data;
  assign bus.wb_fu    = wb_q.fu;
  assign bus.wb_spec  = wb_q.spec;

endmodule
